kgd_fill: RTL and testbench



---
 rtl/kgd_pkg.sv | 19 +
 rtl/kgd_wbm_xfer.sv | 66 ++++++
 rtl/kgd_fill.sv | 134 +++++++++++++
 tb/tb_kgd_fill.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kgd_pkg.sv
// kgd_pkg: KGD register offsets, video address width and fill FSM state type
// Macro KGD_FILL_READBACK_EN adds the RD_DAT state.
package kgd_pkg;
    localparam int KGD_AW = 14;
    localparam logic [2:0] KGD_CSR   = 3'b000;
    localparam logic [2:0] KGD_DATA  = 3'b010;
    localparam logic [2:0] KGD_ADDR  = 3'b100;
    localparam logic [2:0] KGD_COUNT = 3'b110;
    typedef enum logic [2:0] {
        IDLE,
        WR_ADR,
        WR_DAT,
`ifdef KGD_FILL_READBACK_EN
        RD_DAT,
`endif
        GAP,
        DONE
    } kgd_state_e;
endpackage

// File: rtl/kgd_wbm_xfer.sv
// kgd_wbm_xfer: single-transaction Wishbone master with ack timeout and wait-for-ack-low
// Ports: i_req/i_we/i_adr/i_sel/i_dat launch a transaction (registered onto wbm_*);
//        o_ack marks the ack edge, o_done marks ack sampled low afterwards,
//        o_timeout marks ACK_TIMEOUT stb cycles without ack, o_rdata is wbm_dat_i.
module kgd_wbm_xfer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_adr,
    input  logic [1:0]  i_sel,
    input  logic [15:0] i_dat,
    output logic        o_ack,
    output logic        o_done,
    output logic        o_timeout,
    output logic [15:0] o_rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_adr_o,
    output logic [1:0]  wbm_sel_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    logic       r_stb;
    logic       r_wait;
    logic [3:0] r_cnt;
    assign o_ack     = r_stb & wbm_ack_i;
    assign o_timeout = r_stb & ~wbm_ack_i & (r_cnt == 4'(ACK_TIMEOUT - 1));
    // the responder may hold ack for several cycles; the transaction ends only once it is low
    assign o_done    = r_wait & ~wbm_ack_i;
    assign o_rdata   = wbm_dat_i;
    assign wbm_cyc_o = r_stb;
    assign wbm_stb_o = r_stb;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_stb     <= 1'b0;
            r_wait    <= 1'b0;
            r_cnt     <= '0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_sel_o <= '0;
            wbm_dat_o <= '0;
        end else if (i_req) begin
            r_stb     <= 1'b1;
            r_wait    <= 1'b0;
            r_cnt     <= '0;
            wbm_we_o  <= i_we;
            wbm_adr_o <= i_adr;
            wbm_sel_o <= i_sel;
            wbm_dat_o <= i_dat;
        end else if (o_ack) begin
            r_stb  <= 1'b0;
            r_wait <= 1'b1;
        end else if (o_timeout) begin
            r_stb <= 1'b0;
        end else if (r_stb) begin
            r_cnt <= r_cnt + 4'd1;
        end else if (o_done) begin
            r_wait <= 1'b0;
        end
    end
endmodule

// File: rtl/kgd_fill.sv
// kgd_fill: Wishbone master filling KGD video memory with a repeating 16-bit byte pattern
// Ports: start_i/addr_i/count_i/pattern_i command, abort_i stop request;
//        busy_o, done_o pulse, err_o and aborted_o sticky status; wbm_* Wishbone master.
// Macro KGD_FILL_READBACK_EN: read back and verify every written byte.
module kgd_fill
    import kgd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [13:0] addr_i,
    input  logic [13:0] count_i,
    input  logic [15:0] pattern_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        aborted_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_adr_o,
    output logic [1:0]  wbm_sel_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    kgd_state_e        r_state, r_prev, w_next, w_post, w_fin;
    logic [KGD_AW-1:0] r_addr, r_rem, w_cur;
    logic [15:0]       r_pat, w_dat, w_rdata;
    logic [7:0]        w_byte;
    logic [2:0]        w_adr;
    logic [1:0]        w_sel;
    logic              r_off, r_busy, r_done, r_err, r_abt;
    logic              w_req, w_we, w_ack, w_xdone, w_to, w_dec, w_bad;
    kgd_wbm_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .i_req      (w_req),
        .i_we       (w_we),
        .i_adr      (w_adr),
        .i_sel      (w_sel),
        .i_dat      (w_dat),
        .o_ack      (w_ack),
        .o_done     (w_xdone),
        .o_timeout  (w_to),
        .o_rdata    (w_rdata),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );
`ifdef KGD_FILL_READBACK_EN
    logic w_unused;
    // offset has already advanced past the byte being verified
    assign w_bad    = r_state == RD_DAT && w_ack && w_rdata[7:0] != (r_off ? r_pat[7:0] : r_pat[15:8]);
    assign w_dec    = r_state == GAP && w_xdone && r_prev == RD_DAT;
    assign w_unused = &{1'b0, w_rdata[15:8]};
`else
    logic w_unused;
    assign w_bad    = 1'b0;
    assign w_dec    = r_state == GAP && w_xdone && r_prev == WR_DAT;
    assign w_unused = &{1'b0, w_rdata};
`endif
    always_comb begin
        w_cur  = (r_state == IDLE) ? addr_i : r_addr;
        w_byte = r_off ? r_pat[15:8] : r_pat[7:0];
        // remaining is checked before abort so a fill finishing with abort high is not flagged
        w_fin  = (r_rem == '0 || abort_i || r_err) ? DONE : WR_ADR;
`ifdef KGD_FILL_READBACK_EN
        w_post = (r_prev == WR_ADR) ? WR_DAT : (r_prev == WR_DAT) ? RD_DAT : w_fin;
`else
        w_post = (r_prev == WR_ADR) ? WR_DAT : w_fin;
`endif
        w_next = (r_state == IDLE) ? (!start_i ? IDLE : (count_i == '0) ? DONE : WR_ADR) :
                 (r_state == GAP)  ? (w_xdone ? w_post : GAP) :
                 (r_state == DONE) ? IDLE :
                 w_to ? DONE : w_ack ? GAP : r_state;
        // transaction fields are launched on the edge that enters the transaction state
        w_req  = (r_state == IDLE || r_state == GAP) && w_next != DONE && w_next != r_state;
        w_we   = 1'b1;
`ifdef KGD_FILL_READBACK_EN
        w_we   = w_next != RD_DAT;
`endif
        w_adr  = (w_next == WR_ADR) ? KGD_ADDR : KGD_DATA;
        w_sel  = (w_next == WR_ADR) ? 2'b11 : 2'b01;
        w_dat  = (w_next == WR_ADR) ? {2'b00, w_cur} : {8'h00, w_byte};
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
            r_prev  <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_pat   <= '0;
            r_off   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_abt   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != GAP) r_prev <= r_state;
            r_done <= r_state == DONE;
            if (r_state == IDLE && start_i) begin
                r_addr <= addr_i;
                r_rem  <= count_i;
                r_pat  <= pattern_i;
                r_off  <= 1'b0;
                r_err  <= 1'b0;
                r_abt  <= 1'b0;
                r_busy <= count_i != '0;
            end
            if (r_state == WR_DAT && w_ack) begin
                r_rem  <= r_rem - KGD_AW'(1);
                r_addr <= r_addr + KGD_AW'(1);
                r_off  <= ~r_off;
            end
            if (w_to || w_bad) r_err <= 1'b1;
            if (w_dec && abort_i && r_rem != '0 && !r_err) r_abt <= 1'b1;
            if (r_state == DONE) r_busy <= 1'b0;
        end
    end
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign aborted_o = r_abt;
endmodule

// File: tb/tb_kgd_fill.sv
// tb_kgd_fill: scoreboard bench for kgd_fill against a KGD register-window responder model
module tb_kgd_fill;
    import kgd_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic [13:0] addr_i = '0, count_i = '0;
    logic [15:0] pattern_i = '0;
    logic        busy_o, done_o, err_o, aborted_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [2:0]  wbm_adr_o;
    logic [1:0]  wbm_sel_o;
    logic [15:0] wbm_dat_o, wbm_dat_i;

    always #5 clk = ~clk;

    kgd_fill dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
        .addr_i(addr_i), .count_i(count_i), .pattern_i(pattern_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .aborted_o(aborted_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [1:0]  sel;
        logic [15:0] dat;
    } tx_t;

    tx_t         exp_q[$];
    logic [7:0]  mem [16384];
    logic [7:0]  ref_mem [16384];
    int          vectors = 0, miscompares = 0;
    int          dacks = 0, stbc = 0, d0 = 0, bad_rd = 0;
    bit          noack = 1'b0;
    logic [13:0] areg;
    logic        seen;
    int          hold;

`ifdef KGD_FILL_READBACK_EN
    localparam int TPB = 3;
`else
    localparam int TPB = 2;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = mem[i];
        end
    end

    // KGD responder: ack two edges after stb, held for two cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
            seen      <= 1'b0;
            hold      <= 0;
            areg      <= '0;
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) wbm_ack_i <= 1'b0;
        end else if (!wbm_stb_o || noack) begin
            seen <= 1'b0;
        end else if (!seen) begin
            seen <= 1'b1;
        end else begin
            seen      <= 1'b0;
            wbm_ack_i <= 1'b1;
            hold      <= 2;
            if (wbm_we_o && wbm_adr_o == KGD_ADDR) areg <= wbm_dat_o[13:0];
            else if (wbm_we_o && wbm_adr_o == KGD_DATA) mem[areg] = wbm_dat_o[7:0];
            else wbm_dat_i <= {8'h00, mem[areg] ^ ((bad_rd != 0 && dacks - d0 == bad_rd) ? 8'hFF : 8'h00)};
        end
    end

    // monitor: every acked transaction is popped from the scoreboard and compared
    always @(negedge clk) begin
        tx_t t;
        if (wbm_stb_o) stbc++;
        if (wbm_stb_o && wbm_ack_i) begin
            if (wbm_we_o && wbm_adr_o == KGD_DATA) dacks++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tx: got we=%0b adr=%0h dat=%0h expected none", wbm_we_o, wbm_adr_o, wbm_dat_o);
            end else begin
                t = exp_q.pop_front();
                chk("tx_cyc", wbm_cyc_o, 1);
                chk("tx_we_adr_sel", {wbm_we_o, wbm_adr_o, wbm_sel_o}, {t.we, t.adr, t.sel});
                if (t.we) chk("tx_dat", wbm_dat_o, t.dat);
            end
        end
    end

    task automatic run(input logic [13:0] a, input logic [13:0] n, input logic [15:0] p,
                       input int ab, input int bad, input bit na);
        int nb, lat, c, s0, sexp;
        bit e_err, e_abt;
        logic [13:0] ad;
        logic [7:0] b;
        nb = int'(n);
        e_err = 1'b0;
        e_abt = 1'b0;
        if (ab != 0 && ab < nb) begin nb = ab; e_abt = 1'b1; end
`ifdef KGD_FILL_READBACK_EN
        if (bad != 0 && bad <= nb) begin nb = bad; e_err = 1'b1; e_abt = 1'b0; end
`endif
        if (na && n != 0) begin nb = 0; e_err = 1'b1; e_abt = 1'b0; end
        for (int i = 0; i < nb; i++) begin
            ad = a + 14'(i);
            b = i[0] ? p[15:8] : p[7:0];
            exp_q.push_back({1'b1, KGD_ADDR, 2'b11, {2'b00, ad}});
            exp_q.push_back({1'b1, KGD_DATA, 2'b01, {8'h00, b}});
`ifdef KGD_FILL_READBACK_EN
            exp_q.push_back({1'b0, KGD_DATA, 2'b01, 16'h0000});
`endif
            ref_mem[ad] = b;
        end
        lat  = (na && n != 0) ? 16 : 5 * TPB * nb + 1;
        sexp = (na && n != 0) ? 15 : 3 * TPB * nb;
        noack = na;
        bad_rd = bad;
        d0 = dacks;
        s0 = stbc;
        @(negedge clk);
        addr_i = a;
        count_i = n;
        pattern_i = p;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c = 1;
        chk("busy_start", busy_o, n != 0);
        while (!done_o && c < 1000) begin
            if (ab != 0 && dacks - d0 >= ab) abort_i = 1'b1;
            @(negedge clk);
            c++;
        end
        chk("done_seen", done_o, 1);
        chk("done_latency", c - 1, lat);
        chk("stb_cycles", stbc - s0, sexp);
        @(negedge clk);
        abort_i = 1'b0;
        chk("done_pulse", done_o, 0);
        chk("busy_end", busy_o, 0);
        chk("err", err_o, e_err);
        chk("aborted", aborted_o, e_abt);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int i = -1; i <= nb; i++) begin
            ad = a + 14'(i);
            chk("mem", mem[ad], ref_mem[ad]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ab;
        logic [13:0] a;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we_adr_sel_dat", {wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o}, 0);
        chk("rst_status", {busy_o, done_o, err_o, aborted_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_status", {busy_o, done_o, err_o, aborted_o, wbm_stb_o}, 0);

        run(14'd0, 14'd4, 16'h0000, 0, 0, 1'b0);
        run(14'd100, 14'd3, 16'hAA55, 0, 0, 1'b0);
        chk("dither_100", mem[100], 8'h55);
        chk("dither_101", mem[101], 8'hAA);
        chk("dither_102", mem[102], 8'h55);
        run(14'd16383, 14'd2, 16'h1234, 0, 0, 1'b0);
        run(14'd500, 14'd10, 16'hC3A5, 3, 0, 1'b0);
        run(14'd700, 14'd10, 16'h0FF0, 10, 0, 1'b0);
        run(14'd900, 14'd5, 16'h7E81, 0, 0, 1'b1);
        run(14'd1000, 14'd5, 16'h5AA5, 0, 2, 1'b0);
        run(14'd1200, 14'd0, 16'hFFFF, 0, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 14'(16383 - $urandom_range(0, 5)) : 14'($urandom_range(0, 16383));
            n = $urandom_range(0, 12);
            ab = ($urandom_range(0, 3) == 0 && n != 0) ? $urandom_range(1, n) : 0;
            run(a, 14'(n), 16'($urandom), ab, 0, 1'b0);
        end

        noack = 1'b1;
        @(negedge clk);
        addr_i = 14'd5;
        count_i = 14'd5;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("pre_reset_stb", wbm_stb_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_stb", wbm_stb_o, 0);
        chk("async_reset_cyc", wbm_cyc_o, 0);
        chk("async_reset_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        noack = 1'b0;
        exp_q.delete();
        run(14'd2000, 14'd6, 16'h3C96, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
